// File: rtl/mult_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers.
// Shift-add multiply, restoring divide; one bit per cycle, then sign fix and writeback.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic             unsign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, WB} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd, raw_a, res_hi, res_lo;
  logic             is_div, neg_res, neg_rem, div_zero;

  logic             mt_wr, start_go;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_r2;
  logic [WIDTH+1:0] div_diff;
  logic [2*WIDTH-1:0] product;

  assign mt_wr    = hi_we | lo_we;
  assign start_go = (state == IDLE) && start && !mt_wr;
  assign a_mag    = (!unsign && a[WIDTH-1]) ? -a : a;
  assign b_mag    = (!unsign && b[WIDTH-1]) ? -b : b;

  // acc_hi/acc_lo hold {product} for multiply and {remainder, quotient} for divide
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign div_r2   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = {1'b0, div_r2} - {2'b00, opnd};
  assign product  = {acc_hi, acc_lo};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_go) state_nxt = RUN;
      RUN:  if (count == CW'(1)) state_nxt = FIX;
      FIX:  state_nxt = WB;
      WB:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // An MT write while busy abandons the operation
    if (mt_wr) state_nxt = IDLE;
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      raw_a    <= '0;
      res_hi   <= '0;
      res_lo   <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= (state == WB) && !mt_wr;
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
      case (state)
        IDLE: if (start_go) begin
          is_div   <= op_div;
          raw_a    <= a;
          div_zero <= (b == '0);
          neg_res  <= !unsign && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem  <= !unsign && a[WIDTH-1];
          count    <= CW'(WIDTH);
          acc_hi   <= '0;
          acc_lo   <= op_div ? a_mag : b_mag;
          opnd     <= op_div ? b_mag : a_mag;
        end
        RUN: begin
          count <= count - CW'(1);
          if (is_div) begin
            if (!div_diff[WIDTH+1]) begin
              acc_hi <= div_diff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_r2[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (is_div) begin
            if (div_zero) begin
              res_hi <= raw_a;
              res_lo <= '1;
            end else begin
              res_lo <= neg_res ? -acc_lo : acc_lo;
              res_hi <= neg_rem ? -acc_hi : acc_hi;
            end
          end else begin
            {res_hi, res_lo} <= neg_res ? -product : product;
          end
        end
        WB: if (!mt_wr) begin
          hi <= res_hi;
          lo <= res_lo;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed table, abort/reset sequences, random ops vs arithmetic model.
module tb_mult_div_unit;
  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic clk = 1'b0;
  logic reset, start, op_div, unsign, hi_we, lo_we;
  logic [W-1:0] a, b, wdata;
  logic busy, done;
  logic [W-1:0] hi, lo;

  int passed = 0;
  int total  = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op_div(op_div), .unsign(unsign),
    .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         d;
    logic         u;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] eh;
    logic [W-1:0] el;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definition
  function automatic logic [2*W-1:0] model(input logic d, input logic u,
                                           input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [2*W-1:0] p;
    sx = u ? longint'({32'd0, x}) : longint'($signed(x));
    sy = u ? longint'({32'd0, y}) : longint'($signed(y));
    if (!d) begin
      p = 64'(sx * sy);
      return p;
    end
    if (y == '0) return {x, {W{1'b1}}};
    q = sx / sy;
    r = sx % sy;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  // Issue one op; lat = edges after the start edge until done is seen (0 on timeout)
  task automatic run_op(input logic d, input logic u, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int pulse_at, output int lat, output int busy_gap);
    int k;
    @(negedge clk);
    start = 1'b1; op_div = d; unsign = u; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    k = 0; lat = 0; busy_gap = 0;
    while (lat == 0 && k < 200) begin
      if (k == pulse_at) begin start = 1'b1; op_div = ~d; unsign = ~u; end
      if (k == pulse_at + 1) start = 1'b0;
      @(posedge clk); #1;
      k++;
      if (done) begin
        lat = k;
        if (busy) busy_gap++;
      end else if (!busy) busy_gap++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic do_check(input string name, input logic d, input logic u,
                          input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input int pulse_at);
    int lat, gap;
    run_op(d, u, x, y, pulse_at, lat, gap);
    check({name, " latency"}, W'(lat), W'(LAT));
    check({name, " busy"}, W'(gap), '0);
    check({name, " hi"}, hi, eh);
    check({name, " lo"}, lo, el);
    @(posedge clk); #1;
    check({name, " done_one_cycle"}, W'(done), '0);
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
  endtask

  vec_t vecs[9];

  initial begin
    int lat, gap, cnt;
    logic [W-1:0] prior_hi, x, y;
    logic [2*W-1:0] r;
    logic d, u;

    vecs[0] = '{1'b0, 1'b0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[3] = '{1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{1'b1, 1'b1, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    vecs[6] = '{1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7] = '{1'b1, 1'b1, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[8] = '{1'b1, 1'b0, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF};

    reset = 1'b1; start = 1'b0; op_div = 1'b0; unsign = 1'b0;
    a = '0; b = '0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", W'(busy), '0);
    check("reset done", W'(done), '0);
    check("reset hi", hi, '0);
    check("reset lo", lo, '0);
    @(negedge clk); reset = 1'b0;

    foreach (vecs[i])
      do_check($sformatf("vec%0d", i), vecs[i].d, vecs[i].u, vecs[i].x, vecs[i].y,
               vecs[i].eh, vecs[i].el, -1);

    // start pulsed during RUN is ignored
    do_check("start_while_busy", 1'b0, 1'b0, 32'hFFFFFFFD, 32'h00000005,
             32'hFFFFFFFF, 32'hFFFFFFF1, 4);

    // MTLO mid-run aborts; HI keeps its pre-operation value
    prior_hi = hi;
    @(negedge clk);
    start = 1'b1; op_div = 1'b0; unsign = 1'b1; a = 32'h00001234; b = 32'h00005678;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    lo_we = 1'b1; wdata = 32'hAA55AA55;
    @(posedge clk); #1;
    check("abort busy", W'(busy), '0);
    @(negedge clk); lo_we = 1'b0;
    count_dones(LAT + 4, cnt);
    check("abort no_done", W'(cnt), '0);
    check("abort lo", lo, 32'hAA55AA55);
    check("abort hi", hi, prior_hi);

    // MT writes in IDLE take priority over a simultaneous start
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BADF00D; start = 1'b1;
    a = 32'h7; b = 32'h3; op_div = 1'b1; unsign = 1'b1;
    @(posedge clk); #1;
    check("mt_start busy", W'(busy), '0);
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
    count_dones(LAT + 4, cnt);
    check("mt_start no_done", W'(cnt), '0);
    check("mt_start hi", hi, 32'h0BADF00D);
    check("mt_start lo", lo, 32'h0BADF00D);

    // Reset mid-run clears everything, then a fresh op completes
    @(negedge clk);
    start = 1'b1; op_div = 1'b1; unsign = 1'b0; a = 32'hFFFFFFF9; b = 32'h2;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset busy", W'(busy), '0);
    check("midreset done", W'(done), '0);
    check("midreset hi", hi, '0);
    check("midreset lo", lo, '0);
    @(negedge clk); reset = 1'b0;
    do_check("after_reset", 1'b1, 1'b0, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, -1);

    for (int n = 0; n < 150; n++) begin
      d = 1'($urandom); u = 1'($urandom);
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 7))
        0: y = '0;
        1: y = 32'hFFFFFFFF;
        2: x = 32'h80000000;
        3: y = W'($urandom_range(1, 15));
        default: ;
      endcase
      r = model(d, u, x, y);
      run_op(d, u, x, y, -1, lat, gap);
      check($sformatf("rnd%0d latency", n), W'(lat), W'(LAT));
      check($sformatf("rnd%0d hi d=%0b u=%0b a=%h b=%h", n, d, u, x, y), hi, r[2*W-1:W]);
      check($sformatf("rnd%0d lo d=%0b u=%0b a=%h b=%h", n, d, u, x, y), lo, r[W-1:0]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
